// File: rtl/pulse_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_dispatcher
// Brief    : Per-channel descriptor FIFOs released onto AXIS lanes when a
//            free-running timer reaches each head's start time. Optional
//            late-release flags are built when PULSE_DISPATCHER_LATE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_dispatcher #(
  parameter  int NCH   = 4,
  parameter  int DW    = 32,
  parameter  int TW    = 32,
  parameter  int DEPTH = 8,
  localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [CW-1:0]         s_ch,
  input  logic [TW-1:0]         s_time,
  input  logic [DW-1:0]         s_data,
  output logic [NCH-1:0]        m_axis_tvalid,
  input  logic [NCH-1:0]        m_axis_tready,
  output logic [NCH*DW-1:0]     m_axis_tdata,
  output logic [TW-1:0]         timer,
  input  logic                  timer_clr,
  output logic [NCH*(AW+1)-1:0] ch_level,
  output logic [NCH-1:0]        late_flag,
  input  logic [NCH-1:0]        late_clr
);

  logic [TW-1:0]  timer_q, timer_d;
  logic [NCH-1:0] sel;
  logic [NCH-1:0] full;

  always_comb begin
    timer_d = timer_q + TW'(1);
    if (timer_clr) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  assign timer = timer_q;

  // An out-of-range channel selects nothing, so it is always accepted and dropped.
  for (genvar c = 0; c < NCH; c++) begin : g_sel
    assign sel[c] = (s_ch == CW'(c));
  end

  assign s_ready = ~|(sel & full);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [TW+DW-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             tvalid_q, tvalid_d;
    logic [DW-1:0]    tdata_q, tdata_d;
    logic [TW-1:0]    head_time;
    logic [DW-1:0]    head_data;
    logic [TW-1:0]    slip;
    logic             push, pop, due, out_free;

    assign {head_time, head_data} = mem_q[rd_ptr_q];
    // Modular distance; MSB clear means the start time is now or in the past.
    assign slip     = timer_q - head_time;
    assign due      = ~slip[TW-1];
    assign full[c]  = (count_q == (AW+1)'(DEPTH));
    assign push     = s_valid & sel[c] & ~full[c];
    assign out_free = ~tvalid_q | m_axis_tready[c];
    assign pop      = (count_q != '0) & due & out_free;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      tvalid_d = tvalid_q;
      tdata_d  = tdata_q;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (pop) begin
        tvalid_d = 1'b1;
        tdata_d  = head_data;
      end else if (m_axis_tready[c]) begin
        tvalid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        tvalid_q <= 1'b0;
        tdata_q  <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        tvalid_q <= tvalid_d;
        tdata_q  <= tdata_d;
      end
    end

    // Storage needs no reset: the pointers alone define what is valid.
    always_ff @(posedge clk) begin
      if (push) begin
        mem_q[wr_ptr_q] <= {s_time, s_data};
      end
    end

    assign m_axis_tvalid[c]                 = tvalid_q;
    assign m_axis_tdata[c*DW +: DW]         = tdata_q;
    assign ch_level[c*(AW+1) +: (AW+1)]     = count_q;

`ifdef PULSE_DISPATCHER_LATE_EN
    logic late_q, late_d;

    always_comb begin
      late_d = (pop & (slip != '0)) | (late_q & ~late_clr[c]);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        late_q <= 1'b0;
      end else begin
        late_q <= late_d;
      end
    end

    assign late_flag[c] = late_q;
`else
    logic unused_late;
    assign unused_late  = ^{late_clr[c], slip};
    assign late_flag[c] = 1'b0;
`endif
  end

endmodule
`default_nettype wire
